// File: rtl/whackamole_pkg.sv
// Shared types and constants for the whack-a-mole scoring path.
// Holds the evaluator state encoding and score/bonus defaults.
package whackamole_pkg;

  typedef enum logic [1:0] {
    ARMED,
    EVAL,
    LOCKOUT,
    OVER
  } state_t;

  localparam int POS_W           = 3;
  localparam int SCORE_W         = 8;
  localparam int BONUS_THRESHOLD = 3;
  localparam int BONUS_POINTS    = 2;

endpackage

// File: rtl/guess_evaluator_debouncer.sv
// button_debouncer: 2-FF synchronizer, debounce counter, press pulse.
// Ports: i_clk, i_restart_game (sync reset), i_btn_raw,
//        o_level (debounced level), o_press (1-cycle rising pulse).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_restart_game,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = r_sync1 ^ r_level;
  // Last of the required run of differing cycles: level flips now.
  assign w_flip = w_diff && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_restart_game) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_btn_raw;
      r_sync1 <= r_sync0;
      r_press <= w_flip && r_sync1;
      if (w_flip) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/guess_evaluator.sv
// guess_evaluator: debounced whack press -> right/wrong pulse, score.
// Ports: i_clk, i_restart_game, i_btn_raw, i_switches,
//   i_mole_position, i_mole_valid, i_game_over -> o_user_guess,
//   o_user_right, o_user_wrong, o_score, o_streak, o_busy.
// Macro STREAK_BONUS_EN: streak >= 3 earns bonus points per hit.
module guess_evaluator
  import whackamole_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LOCKOUT_CYCLES  = 100000000,
  parameter int SCORE_W         = whackamole_pkg::SCORE_W
) (
  input  logic               i_clk,
  input  logic               i_restart_game,
  input  logic               i_btn_raw,
  input  logic [POS_W-1:0]   i_switches,
  input  logic [POS_W-1:0]   i_mole_position,
  input  logic               i_mole_valid,
  input  logic               i_game_over,
  output logic [POS_W-1:0]   o_user_guess,
  output logic               o_user_right,
  output logic               o_user_wrong,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_streak,
  output logic               o_busy
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SAT = '1;
`ifdef STREAK_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  state_t             r_state;
  logic [POS_W-1:0]   r_guess;
  logic [POS_W-1:0]   r_mole;
  logic               r_right;
  logic               r_wrong;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_streak;
  logic               r_busy;
  logic [LW-1:0]      r_lock_cnt;

  logic               w_level;
  logic               w_press;
  logic               w_hit;
  logic               w_bonus;
  logic [SCORE_W-1:0] w_streak_nx;
  logic [SCORE_W-1:0] w_score_nx;

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [1:0]         inc
  );
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(inc);
    return s[SCORE_W] ? SAT : s[SCORE_W-1:0];
  endfunction

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .i_clk          (i_clk),
    .i_restart_game (i_restart_game),
    .i_btn_raw      (i_btn_raw),
    .o_level        (w_level),
    .o_press        (w_press)
  );

  assign w_hit       = (r_guess == r_mole);
  assign w_streak_nx = sat_add(r_streak, 2'd1);
  assign w_bonus     = BONUS_EN &&
                       (w_streak_nx >= SCORE_W'(BONUS_THRESHOLD));
  assign w_score_nx  = sat_add(r_score,
                       w_bonus ? 2'(BONUS_POINTS) : 2'd1);

  always_ff @(posedge i_clk) begin
    if (i_restart_game) begin
      r_state    <= ARMED;
      r_guess    <= '0;
      r_mole     <= '0;
      r_right    <= 1'b0;
      r_wrong    <= 1'b0;
      r_score    <= '0;
      r_streak   <= '0;
      r_busy     <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_right <= 1'b0;
      r_wrong <= 1'b0;
      // Game over preempts everything, including an EVAL in flight.
      if (i_game_over) begin
        r_state <= OVER;
        r_busy  <= 1'b1;
      end else begin
        unique case (r_state)
          ARMED: begin
            r_guess <= i_switches;
            if (w_press && i_mole_valid) begin
              r_mole  <= i_mole_position;
              r_state <= EVAL;
              r_busy  <= 1'b1;
            end
          end
          EVAL: begin
            r_right <= w_hit;
            r_wrong <= !w_hit;
            if (w_hit) begin
              r_streak <= w_streak_nx;
              r_score  <= w_score_nx;
            end else begin
              r_streak <= '0;
            end
            r_lock_cnt <= '0;
            r_state    <= LOCKOUT;
          end
          LOCKOUT: begin
            // Hold until expired and the button has been released.
            if (r_lock_cnt != LOCK_LAST) begin
              r_lock_cnt <= r_lock_cnt + LW'(1);
            end else if (!w_level) begin
              r_state <= ARMED;
              r_busy  <= 1'b0;
            end
          end
          OVER: begin
            r_busy <= 1'b1;
          end
          default: begin
            r_state <= ARMED;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_user_guess = r_guess;
  assign o_user_right = r_right;
  assign o_user_wrong = r_wrong;
  assign o_score      = r_score;
  assign o_streak     = r_streak;
  assign o_busy       = r_busy;

endmodule

// File: doc/guess_evaluator.md
Name: guess_evaluator

Overview:
- Front end of the whack-a-mole scoring path.
- Takes the player's 3-bit position switches and a raw "whack" push-button, then debounces the button.
- On each accepted press, compares the guess against the current mole position.
- Produces the one-cycle right/wrong pulses, the displayed guess and the running score consumed by the LED display and score display blocks.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before the debounced button level changes (10 ms @ 100 MHz).
- LOCKOUT_CYCLES, 100000000, cycles after an evaluation during which presses are ignored; equals the LED animation length.
- SCORE_W, 8, score/streak counter width.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_restart_game  in  1  synchronous, active-high reset/restart.
- i_btn_raw  in  1  asynchronous raw whack button, active-high.
- i_switches  in  3  player position switches.
- i_mole_position  in  3  current mole position from the mole generator.
- i_mole_valid  in  1  mole position is meaningful this cycle.
- i_game_over  in  1  game timer expired, level.
- o_user_guess  out  3  guess for display.
- o_user_right  out  1  one-cycle pulse, correct guess.
- o_user_wrong  out  1  one-cycle pulse, wrong guess.
- o_score  out  SCORE_W  accumulated score, saturating.
- o_streak  out  SCORE_W  consecutive correct guesses, saturating.
- o_busy  out  1  high outside ARMED.

Behaviour:
- Reset: i_restart_game sampled at posedge i_clk. It wins over every other input.
- Reset values: state=ARMED, o_user_guess=0, o_user_right=0, o_user_wrong=0, o_score=0, o_streak=0, o_busy=0, debounced level=0, both counters=0.
- Button path: 2-FF synchronizer, then debouncer.
  - Debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - press_evt = one-cycle pulse on the debounced rising edge.
- State ARMED:
  - o_user_guess follows i_switches, registered (1-cycle delay).
  - On press_evt with i_mole_valid=1: latch i_switches and i_mole_position, go to EVAL.
  - On press_evt with i_mole_valid=0: ignore, stay in ARMED.
- State EVAL (exactly 1 cycle):
  - On the exiting edge, assert o_user_right if guess==mole, else o_user_wrong, for exactly one cycle.
  - On the same edge: if right, o_score+=1 and o_streak+=1; if wrong, o_streak=0.
  - Both counters saturate at 2^SCORE_W-1.
  - Next state LOCKOUT.
- Latency: press_evt in cycle N; EVAL in N+1; pulse and updated score visible in N+2.
- State LOCKOUT:
  - o_user_guess frozen at the latched guess; press_evt ignored.
  - Counter runs to LOCKOUT_CYCLES-1.
  - Return to ARMED only when the count has expired AND debounced level=0. A held button never re-fires.
- State OVER:
  - Entered at the next edge from any state when i_game_over=1.
  - No pulses; score and streak frozen; o_busy=1.
  - Leaves only via i_restart_game.
- Simultaneous events:
  - i_game_over during EVAL: OVER taken, no pulse, no score change.
  - Restart and game_over together: reset wins.
- o_user_right and o_user_wrong are never high together and are never high in consecutive cycles.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined: a correct guess that raises o_streak to 3 or more adds 2 to o_score instead of 1, still saturating.
- Undefined: every correct guess adds exactly 1.

Decomposition:
- Package whackamole_pkg:
  - state enum {ARMED, EVAL, LOCKOUT, OVER}.
  - POS_W=3, SCORE_W default, BONUS_THRESHOLD=3, BONUS_POINTS=2.
- Sub-module button_debouncer: synchronizer + debounce counter + rising-edge pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Ports i_clk, i_restart_game, i_btn_raw, o_level, o_press.

Test Plan (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10):
- Correct guess: mole=5 valid, switches=5, clean press held 20 cycles -> single o_user_right pulse 2 cycles after press_evt; o_score=1, o_streak=1, o_user_wrong stays 0.
- Wrong guess: mole=2, switches=6 -> single o_user_wrong pulse; o_score unchanged; o_streak=0; o_user_guess=6 held through LOCKOUT.
- Bounce rejection: button toggles every 2 cycles for 12 cycles, then stable high -> exactly one evaluation. Press while i_mole_valid=0 -> no pulse, state stays ARMED.
- Lockout and held button: button held 40 cycles after an evaluation -> no second pulse; second evaluation only after release, then a re-press following the 10-cycle lockout.
- Game over / restart: i_game_over asserted the cycle EVAL is entered -> no pulse, score frozen, o_busy=1. i_restart_game -> all outputs 0 next cycle, state ARMED.
- STREAK_BONUS_EN: 4 correct guesses -> o_score=1,2,4,6 with macro; 1,2,3,4 without. Score preloaded near 255 saturates at 255.
